// File: rtl/uart_boot_loader_if.sv
// Instruction-memory boot interface: serial input from the board pin, write port
// toward the instruction RAM, and CPU reset/status toward the core.
// master = the boot loader, slave = the environment (UART pin, RAM, CPU).
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              uart_rx;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_wren;
    logic              cpu_reset_out;
    logic              boot_done;
    logic              boot_error;

    modport master (
        input  uart_rx,
        output imem_addr,
        output imem_data,
        output imem_wren,
        output cpu_reset_out,
        output boot_done,
        output boot_error
    );

    modport slave (
        output uart_rx,
        input  imem_addr,
        input  imem_data,
        input  imem_wren,
        input  cpu_reset_out,
        input  boot_done,
        input  boot_error
    );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives HEADER, LEN, 4*LEN payload bytes (word MSB byte
// first) over 8N1 serial and writes 32-bit words into the instruction RAM,
// holding the CPU in reset until the whole program is in.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_boot_loader #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ADDR_W = 8,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input logic                clk,
    input logic                reset,
    uart_boot_loader_if.master bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Serial receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // Receiver next state: half-bit start check, then mid-bit sampling.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
`ifdef BOOT_CHECKSUM_EN
        StChk,
`endif
        StDone,
        StError
    } load_state_e;

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Words still to receive; 9 bits so LEN=0 can stand for 256.
    logic [8:0]        words_q, words_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            byte_cnt_q  <= '0;
            words_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            cpu_reset_q <= cpu_reset_d;
            byte_cnt_q  <= byte_cnt_d;
            words_q     <= words_d;
`ifdef BOOT_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    // Sequencer next state: frame parsing, word assembly and write strobe.
    always_comb begin
        state_d    = state_q;
        // Address advances in the cycle after each strobe, wrapping naturally.
        addr_d     = wren_q ? addr_q + 1'b1 : addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
`ifdef BOOT_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            StIdle: begin
                if (rx_valid_q && rx_shift_q == HEADER) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (rx_valid_q) begin
                    addr_d     = '0;
                    words_d    = (rx_shift_q == 8'd0) ? 9'd256 : {1'b0, rx_shift_q};
                    byte_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
                    chk_d      = '0;
`endif
                    state_d    = StData;
                end else if (rx_ferr_q) begin
                    state_d = StError;
                end
            end
            StData: begin
                if (rx_valid_q) begin
                    data_d     = {data_q[23:0], rx_shift_q};
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    chk_d      = chk_q ^ rx_shift_q;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wren_d  = 1'b1;
                        words_d = words_q - 1'b1;
                        if (words_q == 9'd1) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = StChk;
`else
                            state_d = StDone;
`endif
                        end
                    end
                end else if (rx_ferr_q) begin
                    state_d = StError;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            StChk: begin
                if (rx_valid_q) begin
                    state_d = (rx_shift_q == chk_q) ? StDone : StError;
                end else if (rx_ferr_q) begin
                    state_d = StError;
                end
            end
`endif
            StDone, StError: begin
                if (rx_valid_q && rx_shift_q == HEADER) begin
                    state_d = StLen;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // CPU leaves reset only once DONE has been held for a cycle; a re-boot
        // header re-asserts it together with the move to LEN.
        cpu_reset_d = !(state_q == StDone && state_d == StDone);
    end

    assign bus.imem_addr     = addr_q;
    assign bus.imem_data     = data_q;
    assign bus.imem_wren     = wren_q;
    assign bus.cpu_reset_out = cpu_reset_q;
    assign bus.boot_done     = (state_q == StDone);
    assign bus.boot_error    = (state_q == StError);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames over a fast serial line, a
// frame-level model that predicts every RAM write and the final status, and a
// per-cycle compare process that checks each strobe against the prediction.
module tb_uart_boot_loader;

    localparam int unsigned CPB = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_boot_loader_if #(.ADDR_W(8)) bus ();

    uart_boot_loader #(
        .CLK_HZ(600),
        .BAUD  (100),
        .ADDR_W(8),
        .HEADER(8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          vec = 0;
    int          miss = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  pl[$];
    bit          checking = 1'b0;
    bit          exp_done;
    int          exp_addr;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] want);
        vec++;
        if (act !== want) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Per-cycle compare: every strobe must match the next predicted write.
    initial begin
        logic        prev_wren;
        logic [39:0] e;
        bit          bad;
        prev_wren = 1'b0;
        forever begin
            @(negedge clk);
            if (checking && !reset) begin
                vec++;
                bad = 1'b0;
                if (bus.imem_wren === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        bad = 1'b1;
                        $display("FAIL strobe: unexpected write addr %0h data %0h",
                                 bus.imem_addr, bus.imem_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.imem_addr, bus.imem_data} !== e) begin
                            bad = 1'b1;
                            $display("FAIL strobe: got %0h want %0h",
                                     {bus.imem_addr, bus.imem_data}, e);
                        end
                    end
                    if (prev_wren === 1'b1) begin
                        bad = 1'b1;
                        $display("FAIL strobe_gap: got two consecutive strobes want one");
                    end
                end
                if (bus.boot_done !== 1'b1 && bus.cpu_reset_out !== 1'b1) begin
                    bad = 1'b1;
                    $display("FAIL cpu_hold: got cpu_reset_out %0b want 1 while not done",
                             bus.cpu_reset_out);
                end
                if (bus.boot_done === 1'b1 && bus.boot_error === 1'b1) begin
                    bad = 1'b1;
                    $display("FAIL status_excl: got done=1 error=1 want at most one");
                end
                if (bad) miss++;
            end
            prev_wren = reset ? 1'b0 : bus.imem_wren;
        end
    end

    task automatic idle(input int n);
        bus.uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 character, LSB first, followed by a short idle gap.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        bus.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] xor_of(input int nbytes);
        logic [7:0] x = 8'h00;
        for (int j = 0; j < nbytes && j < pl.size(); j++) x ^= pl[j];
        return x;
    endfunction

    // Frame model: predicted writes, final address and outcome.
    task automatic plan_frame(input logic [7:0] len, input int err_idx, input bit chk_bad);
        int nwords;
        int written;
        nwords  = (len == 8'd0) ? 256 : int'(len);
        written = (err_idx >= 0) ? err_idx / 4 : nwords;
        for (int w = 0; w < written; w++) begin
            exp_q.push_back({8'(w), pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]});
        end
        exp_done = (err_idx < 0) && !chk_bad;
        exp_addr = written % 256;
    endtask

    task automatic send_frame(input logic [7:0] len, input int err_idx, input bit chk_bad);
        int nwords;
        nwords = (len == 8'd0) ? 256 : int'(len);
        send_byte(8'hA5, 1'b1);
        send_byte(len, 1'b1);
        for (int j = 0; j < pl.size(); j++) begin
            send_byte(pl[j], j != err_idx);
            if (j == 0 && err_idx != 0) begin
                check("load_cpu_reset", 40'(bus.cpu_reset_out), 40'd1);
                check("load_done", 40'(bus.boot_done), 40'd0);
                check("load_error", 40'(bus.boot_error), 40'd0);
                check("load_addr", 40'(bus.imem_addr), 40'd0);
            end
            if (j == err_idx) break;
        end
`ifdef BOOT_CHECKSUM_EN
        if (err_idx < 0) begin
            send_byte(chk_bad ? (xor_of(4 * nwords) ^ 8'h01) : xor_of(4 * nwords), 1'b1);
        end
`else
        if (chk_bad) $display("note: checksum not built; chk_bad has no effect (%0d words)",
                              nwords);
`endif
    endtask

    task automatic verify_frame();
        idle(20);
        check("boot_done", 40'(bus.boot_done), 40'(exp_done));
        check("boot_error", 40'(bus.boot_error), 40'(!exp_done));
        check("cpu_reset_out", 40'(bus.cpu_reset_out), 40'(!exp_done));
        check("final_addr", 40'(bus.imem_addr), 40'(exp_addr));
        check("pending_writes", 40'(exp_q.size()), 40'd0);
    endtask

    task automatic run_frame(input logic [7:0] len, input int err_idx, input bit chk_bad);
        plan_frame(len, err_idx, chk_bad);
        send_frame(len, err_idx, chk_bad);
        verify_frame();
    endtask

    initial begin
        reset       = 1'b1;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_addr", 40'(bus.imem_addr), 40'd0);
        check("rst_data", 40'(bus.imem_data), 40'd0);
        check("rst_wren", 40'(bus.imem_wren), 40'd0);
        check("rst_cpu_reset", 40'(bus.cpu_reset_out), 40'd1);
        check("rst_done", 40'(bus.boot_done), 40'd0);
        check("rst_error", 40'(bus.boot_error), 40'd0);
        reset    = 1'b0;
        checking = 1'b1;

        // Idle line after reset: CPU stays held, nothing written.
        idle(80);
        check("idle_cpu_reset", 40'(bus.cpu_reset_out), 40'd1);
        check("idle_done", 40'(bus.boot_done), 40'd0);

        // Two-word program.
        pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        plan_frame(8'd2, -1, 1'b0);
        check("model_n2", 40'(exp_q.size()), 40'd2);
        check("model_w0", exp_q[0], 40'h00_12345678);
        check("model_w1", exp_q[1], 40'h01_DEADBEEF);
        send_frame(8'd2, -1, 1'b0);
        verify_frame();

        // Junk in DONE is ignored, then a re-boot with one word.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(10);
        check("junk_keeps_done", 40'(bus.boot_done), 40'd1);
        pl = '{8'h00, 8'h00, 8'h00, 8'h01};
        plan_frame(8'd1, -1, 1'b0);
        check("model_single", exp_q[0], 40'h00_00000001);
        send_frame(8'd1, -1, 1'b0);
        verify_frame();

        // Framing error on the third payload byte, then a clean reload.
        pl = '{8'h11, 8'h22, 8'h33};
        plan_frame(8'd2, 2, 1'b0);
        check("model_ferr_nowrite", 40'(exp_q.size()), 40'd0);
        send_frame(8'd2, 2, 1'b0);
        verify_frame();
        pl = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_frame(8'd1, -1, 1'b0);

        // Reset in the middle of the fourth payload byte: no partial strobe.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        bus.uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset       = 1'b1;
        bus.uart_rx = 1'b1;
        @(negedge clk);
        check("midrst_wren", 40'(bus.imem_wren), 40'd0);
        check("midrst_addr", 40'(bus.imem_addr), 40'd0);
        check("midrst_data", 40'(bus.imem_data), 40'd0);
        check("midrst_cpu_reset", 40'(bus.cpu_reset_out), 40'd1);
        reset = 1'b0;
        idle(12 * CPB);
        check("midrst_done", 40'(bus.boot_done), 40'd0);
        check("midrst_error", 40'(bus.boot_error), 40'd0);

        // LEN=0 means 256 words; address wraps back to 0 afterwards.
        pl.delete();
        for (int j = 0; j < 1024; j++) pl.push_back(8'((j * 7 + 3) & 255));
        plan_frame(8'd0, -1, 1'b0);
        check("model_n256", 40'(exp_q.size()), 40'd256);
        check("model_w255", exp_q[255], {8'hFF, 8'(1020*7+3), 8'(1021*7+3), 8'(1022*7+3),
                                         8'(1023*7+3)});
        send_frame(8'd0, -1, 1'b0);
        verify_frame();

`ifdef BOOT_CHECKSUM_EN
        // Checksum: matching byte -> DONE, wrong byte -> ERROR with word kept.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        check("model_xor", 40'(xor_of(4)), 40'h44);
        run_frame(8'd1, -1, 1'b0);
        run_frame(8'd1, -1, 1'b1);
`endif

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
